// File: rtl/integer_execute_pkg.sv
// integer_execute_pkg
//   Shared definitions for the integer execute stage: datapath widths, the
//   packed issue-buffer record handed over by the integer issue queue, and
//   the funct3 encodings used by the ALU and by the branch comparator.
package integer_execute_pkg;

  localparam int XLEN         = 32;
  localparam int ROB_ID_WIDTH = 6;

  // ALU operation encodings (funct3)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch comparison encodings (funct3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // One issued integer instruction as held in the issue queue's issue buffer.
  // is_j_type marks jal; jalr has its own flag because its target is
  // register-relative.
  typedef struct packed {
    logic                    entry_valid;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         src1_data;
    logic [XLEN-1:0]         src2_data;
    logic [XLEN-1:0]         imm;
    logic [2:0]              funct3;
    logic                    is_r_type;
    logic                    is_u_type;
    logic                    is_lui;
    logic                    is_b_type;
    logic                    is_j_type;
    logic                    is_jalr;
    logic                    is_sub;
    logic                    is_sra_srai;
    logic                    dst_valid;
    logic                    br_dir_pred;
    logic [XLEN-1:0]         br_target_pred;
  } iiq_issue_data_t;

  localparam int IIQ_ISSUE_DATA_WIDTH = $bits(iiq_issue_data_t);

endpackage

// File: rtl/integer_execute_int_alu.sv
// int_alu
//   Purely combinational datapath of the integer execute stage: operand
//   select, ALU, U-type / link results, branch compare, actual direction and
//   target, and misprediction detection.
// Ports:
//   pc, src1_data, src2_data, imm  instruction operands
//   funct3, is_*                   decoded instruction class and op flags
//   br_dir_pred, br_target_pred    front-end prediction
//   result                         value written to the destination register
//   taken                          actual direction (1 for jal/jalr)
//   redirect_pc                    correct next PC (target or pc+4)
//   mispred                        control instruction was mispredicted
module int_alu
  import integer_execute_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1_data,
  input  logic [XLEN-1:0] src2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            is_r_type,
  input  logic            is_u_type,
  input  logic            is_lui,
  input  logic            is_b_type,
  input  logic            is_j_type,
  input  logic            is_jalr,
  input  logic            is_sub,
  input  logic            is_sra_srai,
  input  logic            br_dir_pred,
  input  logic [XLEN-1:0] br_target_pred,
  output logic [XLEN-1:0] result,
  output logic            taken,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mispred
);

  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            br_cond;
  logic            is_ctrl;

  // Branches compare two registers, so they take src2 like R-type ops.
  assign op_b  = (is_r_type | is_b_type) ? src2_data : imm;
  assign shamt = op_b[4:0];

  assign pc_plus_imm = pc + imm;
  assign pc_plus_4   = pc + XLEN'(4);
  assign jalr_sum    = src1_data + imm;
  assign target      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;

  always_comb begin
    alu_out = '0;
    case (funct3)
      F3_ADD_SUB: alu_out = (is_r_type & is_sub) ? (src1_data - op_b)
                                                 : (src1_data + op_b);
      F3_SLL:     alu_out = src1_data << shamt;
      F3_SLT:     alu_out = {{(XLEN-1){1'b0}}, ($signed(src1_data) < $signed(op_b))};
      F3_SLTU:    alu_out = {{(XLEN-1){1'b0}}, (src1_data < op_b)};
      F3_XOR:     alu_out = src1_data ^ op_b;
      F3_SRL_SRA: alu_out = is_sra_srai ? XLEN'($signed(src1_data) >>> shamt)
                                        : (src1_data >> shamt);
      F3_OR:      alu_out = src1_data | op_b;
      F3_AND:     alu_out = src1_data & op_b;
      default:    alu_out = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (src1_data == src2_data);
      F3_BNE:  br_cond = (src1_data != src2_data);
      F3_BLT:  br_cond = ($signed(src1_data) <  $signed(src2_data));
      F3_BGE:  br_cond = ($signed(src1_data) >= $signed(src2_data));
      F3_BLTU: br_cond = (src1_data <  src2_data);
      F3_BGEU: br_cond = (src1_data >= src2_data);
      default: br_cond = 1'b0;
    endcase
  end

  // Branches have no destination; their writeback carries 0.
  always_comb begin
    result = alu_out;
    if (is_u_type)
      result = is_lui ? imm : pc_plus_imm;
    else if (is_j_type | is_jalr)
      result = pc_plus_4;
    else if (is_b_type)
      result = '0;
  end

  assign is_ctrl     = is_b_type | is_j_type | is_jalr;
  assign taken       = is_b_type ? br_cond : (is_j_type | is_jalr);
  assign redirect_pc = taken ? target : pc_plus_4;

  // A correctly predicted not-taken branch is fine whatever target was guessed.
  assign mispred = is_ctrl & ((taken != br_dir_pred) |
                              (taken & (target != br_target_pred)));

endmodule

// File: rtl/integer_execute.sv
// integer_execute
//   Single-cycle integer execute stage fed by the integer issue buffer.
//   Broadcasts the result combinationally for capture/bypass, registers the
//   ROB writeback and fetch redirect, and keeps saturating branch counters.
// Ports:
//   clk, rst_aL                 clock, synchronous active-low reset
//   issue_data                  packed iiq_issue_data_t from the issue buffer
//   alu_broadcast_*             same-cycle result broadcast
//   rob_wb_*                    registered ROB completion
//   fetch_redirect_valid/pc     registered one-cycle redirect (pipeline flush)
//   br_count, mispred_count     saturating performance counters
module integer_execute
  import integer_execute_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_aL,
  input  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data,
  output logic                            alu_broadcast_valid,
  output logic [ROB_ID_WIDTH-1:0]         alu_broadcast_rob_id,
  output logic [XLEN-1:0]                 alu_broadcast_reg_data,
  output logic                            rob_wb_valid,
  output logic [ROB_ID_WIDTH-1:0]         rob_wb_rob_id,
  output logic [XLEN-1:0]                 rob_wb_data,
  output logic                            rob_wb_mispred,
  output logic                            fetch_redirect_valid,
  output logic [XLEN-1:0]                 fetch_redirect_pc,
  output logic [CNT_WIDTH-1:0]            br_count,
  output logic [CNT_WIDTH-1:0]            mispred_count
);

  iiq_issue_data_t iss;
  logic [XLEN-1:0] result;
  logic            taken;
  logic [XLEN-1:0] redirect_pc;
  logic            mispred;
  logic            exec_ok;
  logic            is_ctrl;

  logic                    reg_wb_valid;
  logic [ROB_ID_WIDTH-1:0] reg_wb_rob_id;
  logic [XLEN-1:0]         reg_wb_data;
  logic                    reg_wb_mispred;
  logic                    reg_redirect_valid;
  logic [XLEN-1:0]         reg_redirect_pc;
  logic [CNT_WIDTH-1:0]    reg_br_count;
  logic [CNT_WIDTH-1:0]    reg_mispred_count;

  assign iss = iiq_issue_data_t'(issue_data);

  int_alu u_int_alu (
    .pc             (iss.pc),
    .src1_data      (iss.src1_data),
    .src2_data      (iss.src2_data),
    .imm            (iss.imm),
    .funct3         (iss.funct3),
    .is_r_type      (iss.is_r_type),
    .is_u_type      (iss.is_u_type),
    .is_lui         (iss.is_lui),
    .is_b_type      (iss.is_b_type),
    .is_j_type      (iss.is_j_type),
    .is_jalr        (iss.is_jalr),
    .is_sub         (iss.is_sub),
    .is_sra_srai    (iss.is_sra_srai),
    .br_dir_pred    (iss.br_dir_pred),
    .br_target_pred (iss.br_target_pred),
    .result         (result),
    .taken          (taken),
    .redirect_pc    (redirect_pc),
    .mispred        (mispred)
  );

  // While our own redirect is high, the issue buffer holds a wrong-path
  // instruction younger than the branch; it must leave no trace at all.
  assign exec_ok = iss.entry_valid & ~reg_redirect_valid;
  assign is_ctrl = iss.is_b_type | iss.is_j_type | iss.is_jalr;

  assign alu_broadcast_valid    = exec_ok & iss.dst_valid;
  assign alu_broadcast_rob_id   = iss.rob_id;
  assign alu_broadcast_reg_data = result;

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      reg_wb_valid       <= 1'b0;
      reg_wb_rob_id      <= '0;
      reg_wb_data        <= '0;
      reg_wb_mispred     <= 1'b0;
      reg_redirect_valid <= 1'b0;
      reg_redirect_pc    <= '0;
      reg_br_count       <= '0;
      reg_mispred_count  <= '0;
    end else begin
      reg_wb_valid       <= exec_ok;
      reg_redirect_valid <= exec_ok & mispred;
      reg_redirect_pc    <= redirect_pc;
      if (exec_ok) begin
        reg_wb_rob_id  <= iss.rob_id;
        reg_wb_data    <= result;
        reg_wb_mispred <= mispred;
      end
      if (exec_ok & is_ctrl & (reg_br_count != '1))
        reg_br_count <= reg_br_count + 1'b1;
      if (exec_ok & mispred & (reg_mispred_count != '1))
        reg_mispred_count <= reg_mispred_count + 1'b1;
    end
  end

  assign rob_wb_valid         = reg_wb_valid;
  assign rob_wb_rob_id        = reg_wb_rob_id;
  assign rob_wb_data          = reg_wb_data;
  assign rob_wb_mispred       = reg_wb_mispred;
  assign fetch_redirect_valid = reg_redirect_valid;
  assign fetch_redirect_pc    = reg_redirect_pc;
  assign br_count             = reg_br_count;
  assign mispred_count        = reg_mispred_count;

endmodule

// File: tb/tb_integer_execute.sv
// tb_integer_execute
//   Directed-vector bench for integer_execute with a queue-based scoreboard.
module tb_integer_execute;
  import integer_execute_pkg::*;

  localparam int CW = 4;

  logic                            clk;
  logic                            rst_aL;
  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data;
  logic                            alu_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0]         alu_broadcast_rob_id;
  logic [XLEN-1:0]                 alu_broadcast_reg_data;
  logic                            rob_wb_valid;
  logic [ROB_ID_WIDTH-1:0]         rob_wb_rob_id;
  logic [XLEN-1:0]                 rob_wb_data;
  logic                            rob_wb_mispred;
  logic                            fetch_redirect_valid;
  logic [XLEN-1:0]                 fetch_redirect_pc;
  logic [CW-1:0]                   br_count;
  logic [CW-1:0]                   mispred_count;

  integer_execute #(.CNT_WIDTH(CW)) dut (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .issue_data             (issue_data),
    .alu_broadcast_valid    (alu_broadcast_valid),
    .alu_broadcast_rob_id   (alu_broadcast_rob_id),
    .alu_broadcast_reg_data (alu_broadcast_reg_data),
    .rob_wb_valid           (rob_wb_valid),
    .rob_wb_rob_id          (rob_wb_rob_id),
    .rob_wb_data            (rob_wb_data),
    .rob_wb_mispred         (rob_wb_mispred),
    .fetch_redirect_valid   (fetch_redirect_valid),
    .fetch_redirect_pc      (fetch_redirect_pc),
    .br_count               (br_count),
    .mispred_count          (mispred_count)
  );

  typedef struct {
    logic [ROB_ID_WIDTH-1:0] rob;
    logic [XLEN-1:0]         data;
    bit                      mp;
    logic [XLEN-1:0]         rpc;
  } exp_t;

  exp_t bc_q[$];
  exp_t wb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic iiq_issue_data_t r_op(input int rob, input logic [2:0] f3,
      input logic [31:0] s1, input logic [31:0] s2, input bit sub, input bit sra);
    iiq_issue_data_t d;
    d = '0;
    d.entry_valid = 1'b1; d.rob_id = ROB_ID_WIDTH'(rob); d.funct3 = f3;
    d.src1_data = s1; d.src2_data = s2; d.is_r_type = 1'b1;
    d.is_sub = sub; d.is_sra_srai = sra; d.dst_valid = 1'b1;
    d.imm = 32'hDEAD_0000;
    return d;
  endfunction

  function automatic iiq_issue_data_t i_op(input int rob, input logic [2:0] f3,
      input logic [31:0] s1, input logic [31:0] imm);
    iiq_issue_data_t d;
    d = '0;
    d.entry_valid = 1'b1; d.rob_id = ROB_ID_WIDTH'(rob); d.funct3 = f3;
    d.src1_data = s1; d.src2_data = 32'h5555_5555; d.imm = imm;
    d.dst_valid = 1'b1;
    return d;
  endfunction

  function automatic iiq_issue_data_t u_op(input int rob, input bit lui,
      input logic [31:0] pc, input logic [31:0] imm);
    iiq_issue_data_t d;
    d = '0;
    d.entry_valid = 1'b1; d.rob_id = ROB_ID_WIDTH'(rob); d.pc = pc; d.imm = imm;
    d.is_u_type = 1'b1; d.is_lui = lui; d.dst_valid = 1'b1;
    return d;
  endfunction

  function automatic iiq_issue_data_t b_op(input int rob, input logic [2:0] f3,
      input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
      input logic [31:0] imm, input bit pred, input logic [31:0] ptgt);
    iiq_issue_data_t d;
    d = '0;
    d.entry_valid = 1'b1; d.rob_id = ROB_ID_WIDTH'(rob); d.funct3 = f3; d.pc = pc;
    d.src1_data = s1; d.src2_data = s2; d.imm = imm; d.is_b_type = 1'b1;
    d.br_dir_pred = pred; d.br_target_pred = ptgt;
    return d;
  endfunction

  function automatic iiq_issue_data_t j_op(input int rob, input bit jalr,
      input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] imm,
      input bit pred, input logic [31:0] ptgt);
    iiq_issue_data_t d;
    d = '0;
    d.entry_valid = 1'b1; d.rob_id = ROB_ID_WIDTH'(rob); d.pc = pc;
    d.src1_data = s1; d.imm = imm; d.is_j_type = ~jalr; d.is_jalr = jalr;
    d.dst_valid = 1'b1; d.br_dir_pred = pred; d.br_target_pred = ptgt;
    return d;
  endfunction

  // Drives one issue-buffer entry just after a rising edge and records the
  // hand-computed broadcast / writeback it must produce.
  task automatic applyStimulus(input iiq_issue_data_t d, input bit exp_bc,
      input bit exp_wb, input logic [31:0] data, input bit mp,
      input logic [31:0] rpc);
    exp_t e;
    @(posedge clk);
    #2;
    e.rob = d.rob_id; e.data = data; e.mp = mp; e.rpc = rpc;
    if (exp_bc) bc_q.push_back(e);
    if (exp_wb) wb_q.push_back(e);
    issue_data = IIQ_ISSUE_DATA_WIDTH'(d);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    issue_data = '0;
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, " br_count"}, 32'(br_count), 32'(sat(exp_br)));
    checkOutput({tag, " mispred_count"}, 32'(mispred_count), 32'(sat(exp_mp)));
  endtask

  // Broadcast monitor: combinational output sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_aL && alu_broadcast_valid) begin
      if (bc_q.size() == 0) begin
        checkOutput("bc_unexpected", 32'(alu_broadcast_rob_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = bc_q.pop_front();
        checkOutput("bc_rob_id", 32'(alu_broadcast_rob_id), 32'(e.rob));
        checkOutput("bc_data", alu_broadcast_reg_data, e.data);
      end
    end
  end

  // Writeback / redirect monitor: registered outputs sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (rob_wb_valid) begin
      if (wb_q.size() == 0) begin
        checkOutput("wb_unexpected", 32'(rob_wb_rob_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = wb_q.pop_front();
        checkOutput("wb_rob_id", 32'(rob_wb_rob_id), 32'(e.rob));
        checkOutput("wb_data", rob_wb_data, e.data);
        checkOutput("wb_mispred", 32'(rob_wb_mispred), 32'(e.mp));
        checkOutput("redirect_valid", 32'(fetch_redirect_valid), 32'(e.mp));
        if (e.mp) checkOutput("redirect_pc", fetch_redirect_pc, e.rpc);
      end
    end else if (fetch_redirect_valid) begin
      checkOutput("redirect_without_wb", 32'(fetch_redirect_valid), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_aL     = 1'b0;
    issue_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst rob_wb_valid", 32'(rob_wb_valid), 32'd0);
    checkOutput("rst rob_wb_data", rob_wb_data, 32'd0);
    checkOutput("rst redirect_valid", 32'(fetch_redirect_valid), 32'd0);
    checkOutput("rst redirect_pc", fetch_redirect_pc, 32'd0);
    checkOutput("rst bc_valid", 32'(alu_broadcast_valid), 32'd0);
    checkCounters("rst");
    #1 rst_aL = 1'b1;

    // ALU operations
    applyStimulus(r_op(3, F3_ADD_SUB, 32'd5, 32'd7, 1'b0, 1'b0), 1, 1, 32'd12, 0, 0);
    applyStimulus(r_op(4, F3_ADD_SUB, 32'd5, 32'd7, 1'b1, 1'b0), 1, 1, 32'hFFFF_FFFE, 0, 0);
    applyStimulus(r_op(5, F3_SRL_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b1), 1, 1, 32'hF800_0000, 0, 0);
    applyStimulus(r_op(6, F3_SRL_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b0), 1, 1, 32'h0800_0000, 0, 0);
    applyStimulus(i_op(7, F3_SLT, 32'hFFFF_FFFF, 32'd1), 1, 1, 32'd1, 0, 0);
    applyStimulus(i_op(8, F3_SLTU, 32'hFFFF_FFFF, 32'd1), 1, 1, 32'd0, 0, 0);
    applyStimulus(i_op(9, F3_XOR, 32'h0000_F0F0, 32'h0000_0FF0), 1, 1, 32'h0000_FF00, 0, 0);
    applyStimulus(i_op(10, F3_ADD_SUB, 32'hFFFF_FFFF, 32'd1), 1, 1, 32'd0, 0, 0);
    applyStimulus(r_op(11, F3_SLL, 32'h0000_0003, 32'h0000_0024, 1'b0, 1'b0), 1, 1, 32'h0000_0030, 0, 0);
    applyStimulus(u_op(12, 1'b1, 32'h0000_1000, 32'h1234_5000), 1, 1, 32'h1234_5000, 0, 0);
    applyStimulus(u_op(13, 1'b0, 32'h0000_1000, 32'h0000_2000), 1, 1, 32'h0000_3000, 0, 0);

    // beq taken but predicted not-taken; the following entry is wrong-path
    applyStimulus(b_op(14, F3_BEQ, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0, 32'h0), 0, 1, 32'd0, 1, 32'h120);
    exp_br = 1; exp_mp = 1;
    applyStimulus(r_op(15, F3_ADD_SUB, 32'd1, 32'd1, 1'b0, 1'b0), 0, 0, 0, 0, 0);
    checkCounters("beq");

    // jalr correctly predicted, then with wrong target
    applyStimulus(j_op(16, 1'b1, 32'h40, 32'h1001, 32'd4, 1'b1, 32'h1004), 1, 1, 32'h44, 0, 0);
    applyStimulus(j_op(17, 1'b1, 32'h40, 32'h1001, 32'd4, 1'b1, 32'h1000), 1, 1, 32'h44, 1, 32'h1004);
    applyStimulus(i_op(18, F3_OR, 32'd1, 32'd2), 0, 0, 0, 0, 0);
    exp_br = 3; exp_mp = 2;
    checkCounters("jalr");

    // Correctly predicted branches
    applyStimulus(b_op(19, F3_BNE, 32'h200, 32'd4, 32'd4, 32'h10, 1'b0, 32'h0), 0, 1, 32'd0, 0, 0);
    applyStimulus(b_op(20, F3_BLT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h210), 0, 1, 32'd0, 0, 0);
    applyStimulus(b_op(21, F3_BLTU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0), 0, 1, 32'd0, 0, 0);
    // jal predicted not-taken
    applyStimulus(j_op(22, 1'b0, 32'h300, 32'h0, 32'h100, 1'b0, 32'h0), 1, 1, 32'h304, 1, 32'h400);
    exp_br = 7; exp_mp = 3;
    applyStimulus(i_op(23, F3_AND, 32'hF, 32'h3), 0, 0, 0, 0, 0);
    checkCounters("jal");
    idle();

    // Reset asserted while a redirect is pending
    applyStimulus(b_op(24, F3_BEQ, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0, 32'h0), 0, 1, 32'd0, 1, 32'h120);
    @(posedge clk);
    #2;
    rst_aL     = 1'b0;
    issue_data = IIQ_ISSUE_DATA_WIDTH'(r_op(25, F3_ADD_SUB, 32'd1, 32'd1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    exp_br = 0; exp_mp = 0;
    checkOutput("rstmid rob_wb_valid", 32'(rob_wb_valid), 32'd0);
    checkOutput("rstmid rob_wb_rob_id", 32'(rob_wb_rob_id), 32'd0);
    checkOutput("rstmid rob_wb_mispred", 32'(rob_wb_mispred), 32'd0);
    checkOutput("rstmid redirect_valid", 32'(fetch_redirect_valid), 32'd0);
    checkOutput("rstmid redirect_pc", fetch_redirect_pc, 32'd0);
    checkCounters("rstmid");
    #1;
    rst_aL     = 1'b1;
    issue_data = '0;
    @(posedge clk);
    #1;
    checkOutput("idle rob_wb_valid", 32'(rob_wb_valid), 32'd0);

    // Counter saturation: 16 mispredicting branches into 4-bit counters
    for (int i = 0; i < 16; i++) begin
      applyStimulus(b_op(30 + i, F3_BGE, 32'h500, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0), 0, 1, 32'd0, 1, 32'h540);
      exp_br++; exp_mp++;
      applyStimulus(r_op(50, F3_ADD_SUB, 32'd2, 32'd2, 1'b0, 1'b0), 0, 0, 0, 0, 0);
      checkCounters("sat");
    end

    idle();
    idle();
    idle();
    checkOutput("bc_q drained", 32'(bc_q.size()), 32'd0);
    checkOutput("wb_q drained", 32'(wb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
